input_debouncer: RTL and testbench



---
 rtl/input_debouncer.sv | 143 ++++++++++++++
 tb/tb_input_debouncer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// input_debouncer
//
// Clean-up stage in front of the edge impulse generators. The raw, possibly
// bouncing input is brought into the clock domain through a two-flop
// synchroniser. A stable-count state machine then filters it. A change is
// accepted only after N consecutive synchronised samples of the new value.
// The debounced level comes straight from a flip-flop, so it makes exactly
// one transition per accepted input change.
//
// Parameters:
//   N  consecutive new-value samples needed to accept a change (2 <= N <= 2**W)
//   W  width of the stability counter
//
// Ports:
//   clock      in   single clock; all state updates on its rising edge
//   reset_     in   asynchronous reset, active-low
//   x_raw      in   raw asynchronous input
//   x          out  debounced level (registered)
//   changing   out  high while a candidate change is being qualified (registered)
//   fsm_state  out  current filter state, for observation only:
//                   0 STABLE_LOW, 1 WAIT_HIGH, 2 STABLE_HIGH, 3 WAIT_LOW
//
// Handshake: none. x_raw is sampled on every rising edge. x and changing
// are valid on every cycle after reset.
module input_debouncer #(
   parameter int N = 4,
   parameter int W = 3
) (
   input  logic       clock,
   input  logic       reset_,
   input  logic       x_raw,
   output logic       x,
   output logic       changing,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      WAIT_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      WAIT_LOW    = 2'd3
   } state_t;

   // The terminal count is N-1. The sample that would have made it N is the
   // one that accepts the change, so cnt never wraps for N <= 2**W.
   localparam logic [W-1:0] CNT_LAST = W'(N - 1);
   localparam logic [W-1:0] CNT_ZERO = '0;
   localparam logic [W-1:0] CNT_ONE  = W'(1);

   logic         s1;
   logic         s2;
   state_t       state;
   state_t       next_state;
   logic [W-1:0] cnt;
   logic [W-1:0] next_cnt;
   logic         next_x;
   logic         next_changing;

   // Synchroniser, state register and stability counter.
   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= STABLE_LOW;
         cnt   <= CNT_ZERO;
      end else begin
         s1    <= x_raw;
         s2    <= s1;
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   // Next-state and next-count logic. Only s2 is ever looked at.
   always_comb begin
      next_state = state;
      next_cnt   = CNT_ZERO;
      case (state)
         STABLE_LOW: begin
            if (s2) begin
               next_state = WAIT_HIGH;
               next_cnt   = CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (!s2) begin
               // A returning sample rejects the candidate and clears the count.
               next_state = STABLE_LOW;
            end else if (cnt == CNT_LAST) begin
               next_state = STABLE_HIGH;
            end else begin
               next_cnt = cnt + CNT_ONE;
            end
         end
         STABLE_HIGH: begin
            if (!s2) begin
               next_state = WAIT_LOW;
               next_cnt   = CNT_ONE;
            end
         end
         WAIT_LOW: begin
            if (s2) begin
               next_state = STABLE_HIGH;
            end else if (cnt == CNT_LAST) begin
               next_state = STABLE_LOW;
            end else begin
               next_cnt = cnt + CNT_ONE;
            end
         end
         default: begin
            next_state = STABLE_LOW;
         end
      endcase
   end

   // Outputs are decoded from the next state. They are loaded into their own
   // flops on the same edge as the state change, so x has no combinational
   // path from any input.
   always_comb begin
      next_x        = 1'b0;
      next_changing = 1'b0;
      case (next_state)
         STABLE_LOW:  begin next_x = 1'b0; next_changing = 1'b0; end
         WAIT_HIGH:   begin next_x = 1'b0; next_changing = 1'b1; end
         STABLE_HIGH: begin next_x = 1'b1; next_changing = 1'b0; end
         WAIT_LOW:    begin next_x = 1'b1; next_changing = 1'b1; end
         default:     begin next_x = 1'b0; next_changing = 1'b0; end
      endcase
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         x        <= 1'b0;
         changing <= 1'b0;
      end else begin
         x        <= next_x;
         changing <= next_changing;
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer (N=4, W=3).
// The reference model is a run-length filter. It delays x_raw by two samples
// and counts consecutive samples that differ from the accepted level. When
// that count reaches N, it flips the level. changing is high whenever the
// run count is non-zero.
// Inputs are driven on the falling edge. The model is compared on every
// falling edge. Directed windows check literal edge numbers one time unit
// after each rising edge. Edge k of a window is the rising edge that follows
// the k-th drive.
module tb_input_debouncer;

   localparam int N = 4;
   localparam int W = 3;

   logic       clock = 1'b0;
   logic       reset_ = 1'b0;
   logic       x_raw = 1'b0;
   logic       x;
   logic       changing;
   logic [1:0] fsm_state;

   int checks = 0;
   int errors = 0;

   input_debouncer #(.N(N), .W(W)) dut (
      .clock     (clock),
      .reset_    (reset_),
      .x_raw     (x_raw),
      .x         (x),
      .changing  (changing),
      .fsm_state (fsm_state)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   logic m_s1 = 1'b0;
   logic m_s2 = 1'b0;
   logic m_x  = 1'b0;
   int   m_run = 0;

   always @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         m_s1  = 1'b0;
         m_s2  = 1'b0;
         m_x   = 1'b0;
         m_run = 0;
      end else begin
         if (m_s2 != m_x) begin
            m_run = m_run + 1;
            if (m_run == N) begin
               m_x   = ~m_x;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = x_raw;
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clock) begin
      checks = checks + 1;
      if (x !== m_x || changing !== (m_run != 0)) begin
         errors = errors + 1;
         $display("FAIL model_cmp t=%0t: x=%b changing=%b, model x=%b changing=%b",
                  $time, x, changing, m_x, (m_run != 0));
      end
   end

   // ---------------- helpers ----------------
   task automatic check_int(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive pat[k] before edge k for k = 0..len-1. Record the first rise and
   // fall edges of x, the rise and fall counts, the number of edges after
   // which changing was high, and the first such edge.
   task automatic run_pattern(input logic [31:0] pat, input int len,
                              output int rise_at, output int fall_at,
                              output int rises, output int falls,
                              output int chg_cycles, output int chg_first);
      logic prev;
      rise_at = -1; fall_at = -1; rises = 0; falls = 0;
      chg_cycles = 0; chg_first = -1;
      prev = x;
      for (int k = 0; k < len; k++) begin
         @(negedge clock);
         x_raw = pat[k];
         @(posedge clock);
         #1;
         if (x && !prev) begin
            rises++;
            if (rise_at < 0) rise_at = k;
         end
         if (!x && prev) begin
            falls++;
            if (fall_at < 0) fall_at = k;
         end
         if (changing) begin
            chg_cycles++;
            if (chg_first < 0) chg_first = k;
         end
         prev = x;
      end
   endtask

   task automatic settle_low();
      int a, b, c, d, e, f;
      run_pattern(32'd0, 10, a, b, c, d, e, f);
      check_int("settle_x_low", int'(x), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int rise_at, fall_at, rises, falls, chg_cycles, chg_first;

      // Reset held with a toggling input: outputs stay cleared.
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         x_raw = ~x_raw;
         @(posedge clock);
         #1;
         check_int("reset_x", int'(x), 0);
         check_int("reset_changing", int'(changing), 0);
      end
      @(posedge clock);
      #2;
      x_raw  = 1'b1;
      reset_ = 1'b1;
      run_pattern(32'hFFFF_FFFF, 8, rise_at, fall_at, rises, falls, chg_cycles, chg_first);
      check_int("post_reset_rise_edge", rise_at, 5);
      check_int("post_reset_rises", rises, 1);
      settle_low();

      // Clean rise.
      run_pattern(32'hFFFF_FFFF, 9, rise_at, fall_at, rises, falls, chg_cycles, chg_first);
      check_int("clean_rise_edge", rise_at, 5);
      check_int("clean_chg_first", chg_first, 2);
      check_int("clean_chg_cycles", chg_cycles, 3);
      check_int("clean_falls", falls, 0);
      settle_low();

      // Glitch of 3 sampling edges.
      run_pattern(32'h0000_0007, 9, rise_at, fall_at, rises, falls, chg_cycles, chg_first);
      check_int("glitch_rises", rises, 0);
      check_int("glitch_chg_first", chg_first, 2);
      check_int("glitch_chg_cycles", chg_cycles, 3);
      check_int("glitch_x", int'(x), 0);
      check_int("glitch_state", int'(fsm_state), 0);

      // Pulse of exactly N sampling edges is accepted, and the fall is qualified.
      run_pattern(32'h0000_000F, 12, rise_at, fall_at, rises, falls, chg_cycles, chg_first);
      check_int("boundary_rise_edge", rise_at, 5);
      check_int("boundary_fall_edge", fall_at, 9);
      check_int("boundary_rises", rises, 1);
      check_int("boundary_falls", falls, 1);
      check_int("boundary_chg_cycles", chg_cycles, 6);
      settle_low();

      // Bounce 1,0,1,1,0,1,1,1,1 then held high: a single rise at edge 10.
      run_pattern(32'b11111111101101, 14, rise_at, fall_at, rises, falls, chg_cycles, chg_first);
      check_int("bounce_rise_edge", rise_at, 10);
      check_int("bounce_rises", rises, 1);
      check_int("bounce_falls", falls, 0);
      settle_low();

      // Reset in WAIT_HIGH with cnt=2 (after edge 3).
      run_pattern(32'hFFFF_FFFF, 4, rise_at, fall_at, rises, falls, chg_cycles, chg_first);
      check_int("midwait_pre_changing", int'(changing), 1);
      #2;
      reset_ = 1'b0;
      #1;
      check_int("midwait_reset_x", int'(x), 0);
      check_int("midwait_reset_changing", int'(changing), 0);
      check_int("midwait_reset_state", int'(fsm_state), 0);
      repeat (2) @(posedge clock);
      #1;
      check_int("midwait_hold_changing", int'(changing), 0);
      @(posedge clock);
      #2;
      reset_ = 1'b1;
      run_pattern(32'hFFFF_FFFF, 8, rise_at, fall_at, rises, falls, chg_cycles, chg_first);
      check_int("midwait_requal_edge", rise_at, 5);
      check_int("midwait_requal_rises", rises, 1);
      settle_low();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
